// File: rtl/lfsr_pkg.sv
// Shared types and the keystream recurrence for the 16-bit additive LFSR descrambler.
package lfsr_pkg;

    localparam int lp_POLY_SIZE = 16;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } lfsr_state_t;

    // Result of advancing the window: beat bit i is keystream bit i of the beat (bit 0 earliest).
    typedef struct packed {
        logic [lp_POLY_SIZE-1:0] window;
        logic [lp_POLY_SIZE-1:0] beat;
    } lfsr_step_t;

    // window[j] holds k[n+j]; each step appends parity(poly & window) at the top.
    function automatic lfsr_step_t lfsr_advance(
        input logic [lp_POLY_SIZE-1:0] window,
        input logic [lp_POLY_SIZE-1:0] poly,
        input int                      nbits
    );
        lfsr_step_t res;
        logic       fb;
        res.window = window;
        res.beat   = '0;
        for (int i = 0; i < lp_POLY_SIZE; i++) begin
            if (i < nbits) begin
                fb          = ^(poly & res.window);
                res.beat[i] = fb;
                res.window  = {fb, res.window[lp_POLY_SIZE-1:1]};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/lfsr_keystream_gen.sv
// Combinational W-bit look-ahead of the keystream recurrence: predicted beat and advanced window.
module lfsr_keystream_gen
    import lfsr_pkg::*;
#(
    parameter int                      p_BITS_PER_CLOCK = 8,
    parameter logic [lp_POLY_SIZE-1:0] p_POLYNOMIAL     = 16'b1000_0000_0001_1100
) (
    input  logic [lp_POLY_SIZE-1:0]     i_WINDOW,
    output logic [lp_POLY_SIZE-1:0]     o_WINDOW_NEXT,
    output logic [p_BITS_PER_CLOCK-1:0] o_BEAT
);

    lfsr_step_t w_step;
    logic       w_unused_beat;

    assign w_step        = lfsr_advance(i_WINDOW, p_POLYNOMIAL, p_BITS_PER_CLOCK);
    assign o_WINDOW_NEXT = w_step.window;
    assign o_BEAT        = w_step.beat[p_BITS_PER_CLOCK-1:0];

    // Beat bits above W are never produced for narrow beats.
    assign w_unused_beat = ^w_step.beat;

endmodule

// File: rtl/lfsr_descrambler.sv
// Self-synchronising additive LFSR descrambler.
//   state  | meaning
//   HUNT   | loading raw scrambled idle bits into the window
//   VERIFY | checking that idle beats match the predicted keystream
//   LOCKED | descrambling payload, watching checked idle beats for errors
module lfsr_descrambler
    import lfsr_pkg::*;
#(
    parameter int                      p_BITS_PER_CLOCK = 8,
    parameter logic [lp_POLY_SIZE-1:0] p_POLYNOMIAL     = 16'b1000_0000_0001_1100,
    parameter int                      p_VERIFY_BEATS   = 4,
    parameter int                      p_ERR_LIMIT      = 3
) (
    input  logic                        i_CLK,
    input  logic                        i_RESET,
    input  logic                        i_VALID,
    input  logic [p_BITS_PER_CLOCK-1:0] i_DATA_IN,
    input  logic                        i_IDLE_CHECK,
    input  logic                        i_RESYNC,
    output logic                        o_VALID,
    output logic [p_BITS_PER_CLOCK-1:0] o_DATA_OUT,
    output logic                        o_LOCKED,
    output logic [lp_POLY_SIZE-1:0]     o_STATE_OUT,
    output logic [1:0]                  o_ERR_CNT
);

    localparam int lp_W           = p_BITS_PER_CLOCK;
    localparam int lp_HUNT_BEATS  = lp_POLY_SIZE / lp_W;
    localparam int lp_VCNT_W      = $clog2(p_VERIFY_BEATS + 1);

    lfsr_state_t            r_state, w_state_next;
    logic [lp_POLY_SIZE-1:0] r_window, w_window_next;
    logic [4:0]             r_hcnt, w_hcnt_next;
    logic [lp_VCNT_W-1:0]   r_vcnt, w_vcnt_next;
    logic [1:0]             r_err, w_err_next;
    logic                   r_valid, w_valid_next;
    logic [lp_W-1:0]        r_data, w_data_next;
    logic                   r_locked;

    logic [lp_POLY_SIZE-1:0]      w_window_adv;
    logic [lp_W-1:0]              w_pred;
    logic [lp_W+lp_POLY_SIZE-1:0] w_shift_cat;
    logic [lp_POLY_SIZE-1:0]      w_window_hunt;
    logic [lp_W-1:0]              w_desc;
    logic [4:0]                   w_hcnt_inc;
    logic [lp_VCNT_W-1:0]         w_vcnt_inc;
    logic [2:0]                   w_err_inc;

    lfsr_keystream_gen #(
        .p_BITS_PER_CLOCK (p_BITS_PER_CLOCK),
        .p_POLYNOMIAL     (p_POLYNOMIAL)
    ) u_keystream (
        .i_WINDOW      (r_window),
        .o_WINDOW_NEXT (w_window_adv),
        .o_BEAT        (w_pred)
    );

    // Raw beat enters at the top so its earliest bit ends up just above the older bits.
    assign w_shift_cat   = {i_DATA_IN, r_window};
    assign w_window_hunt = w_shift_cat[lp_W+lp_POLY_SIZE-1:lp_W];
    assign w_desc        = i_DATA_IN ^ w_pred;
    assign w_hcnt_inc    = r_hcnt + 5'd1;
    assign w_vcnt_inc    = r_vcnt + lp_VCNT_W'(1);
    assign w_err_inc     = {1'b0, r_err} + 3'd1;

    // Next-state, window, counters and output data.
    always_comb begin
        w_state_next  = r_state;
        w_window_next = r_window;
        w_hcnt_next   = r_hcnt;
        w_vcnt_next   = r_vcnt;
        w_err_next    = r_err;
        w_valid_next  = 1'b0;
        w_data_next   = r_data;

        if (i_RESYNC) begin
            w_state_next = HUNT;
            w_hcnt_next  = '0;
            w_vcnt_next  = '0;
            w_err_next   = '0;
        end else if (i_VALID) begin
            unique case (r_state)
                HUNT: begin
                    w_window_next = w_window_hunt;
                    // An all-zero window would predict zeros forever; keep hunting.
                    if (w_window_hunt == '0) begin
                        w_hcnt_next = '0;
                    end else if (w_hcnt_inc == 5'(lp_HUNT_BEATS)) begin
                        w_state_next = VERIFY;
                        w_hcnt_next  = '0;
                        w_vcnt_next  = '0;
                    end else begin
                        w_hcnt_next = w_hcnt_inc;
                    end
                end
                VERIFY: begin
                    if (i_DATA_IN == w_pred) begin
                        w_window_next = w_window_adv;
                        if (w_vcnt_inc == lp_VCNT_W'(p_VERIFY_BEATS)) begin
                            w_state_next = LOCKED;
                            w_vcnt_next  = '0;
                            w_err_next   = '0;
                        end else begin
                            w_vcnt_next = w_vcnt_inc;
                        end
                    end else begin
                        w_state_next = HUNT;
                        w_hcnt_next  = '0;
                        w_vcnt_next  = '0;
                    end
                end
                LOCKED: begin
                    w_window_next = w_window_adv;
                    w_valid_next  = 1'b1;
                    w_data_next   = w_desc;
                    if (i_IDLE_CHECK) begin
                        if (w_desc == '0) begin
                            w_err_next = '0;
                        end else if (w_err_inc >= 3'(p_ERR_LIMIT)) begin
                            w_state_next = HUNT;
                            w_err_next   = '0;
                            w_hcnt_next  = '0;
                            w_vcnt_next  = '0;
                        end else begin
                            w_err_next = w_err_inc[2] ? 2'b11 : w_err_inc[1:0];
                        end
                    end
                end
                default: begin
                    w_state_next = HUNT;
                    w_hcnt_next  = '0;
                    w_vcnt_next  = '0;
                    w_err_next   = '0;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            r_state  <= HUNT;
            r_window <= '0;
            r_hcnt   <= '0;
            r_vcnt   <= '0;
            r_err    <= '0;
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_locked <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_window <= w_window_next;
            r_hcnt   <= w_hcnt_next;
            r_vcnt   <= w_vcnt_next;
            r_err    <= w_err_next;
            r_valid  <= w_valid_next;
            r_data   <= w_data_next;
            r_locked <= (w_state_next == LOCKED);
        end
    end

    assign o_VALID     = r_valid;
    assign o_DATA_OUT  = r_data;
    assign o_LOCKED    = r_locked;
    assign o_STATE_OUT = r_window;
    assign o_ERR_CNT   = r_err;

endmodule

// File: tb/tb_lfsr_descrambler.sv
// Directed bench: a bit-serial transmit scrambler drives the descrambler through lock, payload,
// verify failure, loss of lock, all-zero rejection, resync and reset.
module tb_lfsr_descrambler;

    localparam logic [15:0] lp_POLY = 16'b1000_0000_0001_1100;

    logic        i_CLK;
    logic        i_RESET;
    logic        i_VALID;
    logic [7:0]  i_DATA_IN;
    logic        i_IDLE_CHECK;
    logic        i_RESYNC;
    logic        o_VALID;
    logic [7:0]  o_DATA_OUT;
    logic        o_LOCKED;
    logic [15:0] o_STATE_OUT;
    logic [1:0]  o_ERR_CNT;

    logic [15:0] tx_w;
    int          n_pass;
    int          n_total;

    lfsr_descrambler #(
        .p_BITS_PER_CLOCK (8),
        .p_POLYNOMIAL     (lp_POLY),
        .p_VERIFY_BEATS   (4),
        .p_ERR_LIMIT      (3)
    ) dut (
        .i_CLK        (i_CLK),
        .i_RESET      (i_RESET),
        .i_VALID      (i_VALID),
        .i_DATA_IN    (i_DATA_IN),
        .i_IDLE_CHECK (i_IDLE_CHECK),
        .i_RESYNC     (i_RESYNC),
        .o_VALID      (o_VALID),
        .o_DATA_OUT   (o_DATA_OUT),
        .o_LOCKED     (o_LOCKED),
        .o_STATE_OUT  (o_STATE_OUT),
        .o_ERR_CNT    (o_ERR_CNT)
    );

    initial begin
        i_CLK = 1'b0;
        forever #5 i_CLK = ~i_CLK;
    end

    // Drive at a falling edge, then return at the next falling edge with that beat's results visible.
    task automatic step(input logic [7:0] d, input logic v, input logic idle, input logic rs);
        i_DATA_IN    = d;
        i_VALID      = v;
        i_IDLE_CHECK = idle;
        i_RESYNC     = rs;
        @(negedge i_CLK);
    endtask

    // Transmit scrambler: the sent beat is data ^ keystream, optionally corrupted by flip.
    task automatic tx_send(input logic [7:0] d, input logic [7:0] flip, input logic idle,
                           input logic rs, output logic [7:0] sent);
        logic k;
        for (int i = 0; i < 8; i++) begin
            k       = ^(lp_POLY & tx_w);
            sent[i] = d[i] ^ k;
            tx_w    = {k, tx_w[15:1]};
        end
        sent = sent ^ flip;
        step(sent, 1'b1, idle, rs);
    endtask

    task automatic do_reset();
        i_RESET = 1'b1;
        step(8'h00, 1'b0, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0, 1'b0);
        i_RESET = 1'b0;
        tx_w = 16'hFFFF;
    endtask

    task automatic lock_up();
        logic [7:0] s;
        for (int b = 0; b < 6; b++) tx_send(8'h00, 8'h00, 1'b0, 1'b0, s);
    endtask

    task automatic test_reset();
        do_reset();
        if (o_VALID !== 1'b0) $display("FAIL reset_valid: got %b want 0", o_VALID); else n_pass++;
        n_total++;
        if (o_DATA_OUT !== 8'h00) $display("FAIL reset_data: got %h want 00", o_DATA_OUT); else n_pass++;
        n_total++;
        if (o_LOCKED !== 1'b0) $display("FAIL reset_locked: got %b want 0", o_LOCKED); else n_pass++;
        n_total++;
        if (o_STATE_OUT !== 16'h0000) $display("FAIL reset_state: got %h want 0000", o_STATE_OUT); else n_pass++;
        n_total++;
        if (o_ERR_CNT !== 2'd0) $display("FAIL reset_err: got %0d want 0", o_ERR_CNT); else n_pass++;
        n_total++;
    endtask

    task automatic test_lock();
        logic [7:0] s;
        logic [7:0] s1;
        do_reset();
        for (int b = 1; b <= 6; b++) begin
            tx_send(8'h00, 8'h00, 1'b0, 1'b0, s);
            if (b == 1) s1 = s;
            if (b == 2) begin
                if (o_STATE_OUT !== {s, s1})
                    $display("FAIL lock_window: got %h want %h", o_STATE_OUT, {s, s1});
                else n_pass++;
                n_total++;
            end
            if (o_LOCKED !== (b == 6))
                $display("FAIL lock_timing beat %0d: got %b want %b", b, o_LOCKED, (b == 6));
            else n_pass++;
            n_total++;
            if (o_VALID !== 1'b0) $display("FAIL lock_acq_valid beat %0d: got %b want 0", b, o_VALID);
            else n_pass++;
            n_total++;
        end
        for (int b = 0; b < 2; b++) begin
            tx_send(8'h00, 8'h00, 1'b1, 1'b0, s);
            if (o_VALID !== 1'b1 || o_DATA_OUT !== 8'h00)
                $display("FAIL lock_idle_out: got valid %b data %h want 1 00", o_VALID, o_DATA_OUT);
            else n_pass++;
            n_total++;
        end
    endtask

    task automatic test_payload();
        logic [7:0] s;
        logic [7:0] pay [3];
        pay[0] = 8'hA5; pay[1] = 8'h3C; pay[2] = 8'hFF;
        for (int p = 0; p < 3; p++) begin
            tx_send(pay[p], 8'h00, 1'b0, 1'b0, s);
            if (o_VALID !== 1'b1 || o_DATA_OUT !== pay[p])
                $display("FAIL payload_beat %0d: got valid %b data %h want 1 %h", p, o_VALID, o_DATA_OUT, pay[p]);
            else n_pass++;
            n_total++;
            step(8'h00, 1'b0, 1'b0, 1'b0);
            if (o_VALID !== 1'b0 || o_DATA_OUT !== pay[p])
                $display("FAIL payload_stall %0d: got valid %b data %h want 0 %h", p, o_VALID, o_DATA_OUT, pay[p]);
            else n_pass++;
            n_total++;
        end
        if (o_LOCKED !== 1'b1) $display("FAIL payload_locked: got %b want 1", o_LOCKED); else n_pass++;
        n_total++;
    endtask

    task automatic test_loss_of_lock();
        logic [7:0] s;
        logic [1:0] exp_err [5];
        logic [7:0] flip [5];
        flip[0] = 8'h01; flip[1] = 8'h01; flip[2] = 8'h00; flip[3] = 8'h01; flip[4] = 8'h01;
        exp_err[0] = 2'd1; exp_err[1] = 2'd2; exp_err[2] = 2'd0; exp_err[3] = 2'd1; exp_err[4] = 2'd2;
        for (int b = 0; b < 5; b++) begin
            tx_send(8'h00, flip[b], 1'b1, 1'b0, s);
            if (o_ERR_CNT !== exp_err[b] || o_LOCKED !== 1'b1)
                $display("FAIL loss_err beat %0d: got err %0d lock %b want %0d 1", b, o_ERR_CNT, o_LOCKED, exp_err[b]);
            else n_pass++;
            n_total++;
        end
        // An unchecked payload beat leaves the error count alone.
        tx_send(8'h77, 8'h00, 1'b0, 1'b0, s);
        if (o_ERR_CNT !== 2'd2 || o_DATA_OUT !== 8'h77)
            $display("FAIL loss_unchecked: got err %0d data %h want 2 77", o_ERR_CNT, o_DATA_OUT);
        else n_pass++;
        n_total++;
        tx_send(8'h00, 8'h01, 1'b1, 1'b0, s);
        if (o_LOCKED !== 1'b0 || o_VALID !== 1'b1 || o_DATA_OUT !== 8'h01 || o_ERR_CNT !== 2'd0)
            $display("FAIL loss_drop: got lock %b valid %b data %h err %0d want 0 1 01 0",
                     o_LOCKED, o_VALID, o_DATA_OUT, o_ERR_CNT);
        else n_pass++;
        n_total++;
        for (int b = 1; b <= 6; b++) begin
            tx_send(8'h00, 8'h00, 1'b0, 1'b0, s);
            if (o_LOCKED !== (b == 6) || o_VALID !== 1'b0)
                $display("FAIL loss_relock beat %0d: got lock %b valid %b want %b 0", b, o_LOCKED, o_VALID, (b == 6));
            else n_pass++;
            n_total++;
        end
    endtask

    task automatic test_verify_fail();
        logic [7:0] s;
        do_reset();
        for (int b = 1; b <= 12; b++) begin
            tx_send(8'h00, (b == 6) ? 8'h08 : 8'h00, 1'b0, 1'b0, s);
            if (o_LOCKED !== (b == 12) || o_VALID !== 1'b0)
                $display("FAIL verify_fail beat %0d: got lock %b valid %b want %b 0", b, o_LOCKED, o_VALID, (b == 12));
            else n_pass++;
            n_total++;
        end
    endtask

    task automatic test_all_zero();
        logic ever_locked;
        do_reset();
        ever_locked = 1'b0;
        for (int b = 0; b < 20; b++) begin
            step(8'h00, 1'b1, 1'b0, 1'b0);
            if (o_LOCKED === 1'b1) ever_locked = 1'b1;
        end
        if (ever_locked !== 1'b0) $display("FAIL zero_locked: got %b want 0", ever_locked); else n_pass++;
        n_total++;
        if (o_STATE_OUT !== 16'h0000) $display("FAIL zero_window: got %h want 0000", o_STATE_OUT); else n_pass++;
        n_total++;
    endtask

    task automatic test_resync();
        logic [7:0] s;
        do_reset();
        lock_up();
        tx_send(8'h5A, 8'h00, 1'b0, 1'b1, s);
        if (o_VALID !== 1'b0 || o_LOCKED !== 1'b0)
            $display("FAIL resync_beat: got valid %b lock %b want 0 0", o_VALID, o_LOCKED);
        else n_pass++;
        n_total++;
    endtask

    task automatic test_reset_mid_verify();
        logic [7:0] s;
        do_reset();
        lock_up();
        tx_send(8'h5A, 8'h00, 1'b0, 1'b0, s);
        step(8'h00, 1'b0, 1'b0, 1'b1);
        for (int b = 0; b < 3; b++) tx_send(8'h00, 8'h00, 1'b0, 1'b0, s);
        if (o_DATA_OUT !== 8'h5A || o_VALID !== 1'b0 || o_LOCKED !== 1'b0)
            $display("FAIL midverify_hold: got data %h valid %b lock %b want 5a 0 0", o_DATA_OUT, o_VALID, o_LOCKED);
        else n_pass++;
        n_total++;
        i_RESET = 1'b1;
        tx_send(8'h00, 8'h00, 1'b0, 1'b0, s);
        i_RESET = 1'b0;
        if (o_DATA_OUT !== 8'h00 || o_VALID !== 1'b0 || o_LOCKED !== 1'b0 ||
            o_STATE_OUT !== 16'h0000 || o_ERR_CNT !== 2'd0)
            $display("FAIL midverify_reset: got data %h valid %b lock %b win %h err %0d want all 0",
                     o_DATA_OUT, o_VALID, o_LOCKED, o_STATE_OUT, o_ERR_CNT);
        else n_pass++;
        n_total++;
    endtask

    initial begin
        n_pass       = 0;
        n_total      = 0;
        tx_w         = 16'hFFFF;
        i_RESET      = 1'b1;
        i_VALID      = 1'b0;
        i_DATA_IN    = 8'h00;
        i_IDLE_CHECK = 1'b0;
        i_RESYNC     = 1'b0;
        @(negedge i_CLK);
        test_reset();
        test_lock();
        test_payload();
        test_loss_of_lock();
        test_verify_fail();
        test_all_zero();
        test_resync();
        test_reset_mid_verify();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
